// File: rtl/fix_ascii_streamer.sv
// Streams one sign-magnitude fixed-point sample as ASCII: ['-'] digits '.' f3 f2 f1 f0 '\n'.
// Integer part goes through a serial double-dabble; fraction digits come from an external lookup.
module fix_ascii_streamer #(
    parameter int INT_W = 8,
    parameter int NDIG  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_sign,
    input  logic [INT_W-1:0] s_int,
    input  logic [3:0]       s_frac,
    output logic [3:0]       frac_sel,
    input  logic [31:0]      frac_ascii,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last
);
    localparam int BCD_W = 4 * NDIG;
    localparam int IDX_W = (NDIG > 4) ? $clog2(NDIG) : 2;
    localparam int CNT_W = $clog2(INT_W + 1);

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_SIGN, S_INT, S_DOT, S_FRAC, S_EOL} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [INT_W-1:0]   bin_q, bin_d, bin_step;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_step, bcd_adj;
    logic               sign_q, sign_d;
    logic [31:0]        fbuf_q, fbuf_d;
    logic [3:0]         frac_sel_d;
    logic               m_valid_d, m_last_d;
    logic [7:0]         m_data_d;
    state_t             nst;
    logic [IDX_W-1:0]   nix;

    // Index of the most significant non-zero digit; 0 keeps the units digit for a zero value.
    function automatic logic [IDX_W-1:0] lead_digit(input logic [BCD_W-1:0] b);
        lead_digit = '0;
        for (int i = 0; i < NDIG; i++)
            if (b[4*i +: 4] != 4'd0) lead_digit = IDX_W'(i);
    endfunction

    function automatic logic [7:0] byte_of(input state_t st, input logic [IDX_W-1:0] ix,
                                           input logic [BCD_W-1:0] b, input logic [31:0] fb);
        byte_of = 8'h00;
        case (st)
            S_SIGN: byte_of = 8'h2D;
            S_INT:  for (int i = 0; i < NDIG; i++)
                        if (ix == IDX_W'(i)) byte_of = {4'h3, b[4*i +: 4]};
            S_DOT:  byte_of = 8'h2E;
            S_FRAC: for (int i = 0; i < 4; i++)
                        if (ix == IDX_W'(i)) byte_of = fb[8*i +: 8];
            S_EOL:  byte_of = 8'h0A;
            default: byte_of = 8'h00;
        endcase
    endfunction

    // One double-dabble step: add 3 to digits >= 5, then shift the next binary bit in.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NDIG; i++)
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        {bcd_step, bin_step} = {bcd_adj, bin_q} << 1;
    end

    assign s_ready = (state_q == S_IDLE);

    // Successor byte position after a handshake in the current emission state.
    always_comb begin
        nst = state_q;
        nix = idx_q;
        case (state_q)
            S_SIGN: nst = S_INT;
            S_INT:  if (idx_q == '0) nst = S_DOT; else nix = idx_q - 1'b1;
            S_DOT:  begin nst = S_FRAC; nix = IDX_W'(3); end
            S_FRAC: if (idx_q == '0) nst = S_EOL; else nix = idx_q - 1'b1;
            S_EOL:  nst = S_IDLE;
            default: nst = state_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        sign_d     = sign_q;
        fbuf_d     = fbuf_q;
        frac_sel_d = frac_sel;
        m_valid_d  = m_valid;
        m_data_d   = m_data;
        m_last_d   = m_last;
        case (state_q)
            S_IDLE: if (s_valid) begin
                sign_d     = s_sign;
                bin_d      = s_int;
                bcd_d      = '0;
                cnt_d      = '0;
                frac_sel_d = s_frac;
                state_d    = S_CONV;
            end
            S_CONV: begin
                bin_d = bin_step;
                bcd_d = bcd_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(INT_W - 1)) begin
                    fbuf_d  = frac_ascii;
                    idx_d   = lead_digit(bcd_step);
                    state_d = sign_q ? S_SIGN : S_INT;
                end
            end
            default: begin
                // First byte is loaded the cycle after conversion; later bytes load on the handshake.
                if (!m_valid) begin
                    m_valid_d = 1'b1;
                    m_data_d  = byte_of(state_q, idx_q, bcd_q, fbuf_q);
                    m_last_d  = (state_q == S_EOL);
                end else if (m_ready) begin
                    state_d = nst;
                    idx_d   = nix;
                    if (state_q == S_EOL) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                    end else begin
                        m_data_d = byte_of(nst, nix, bcd_q, fbuf_q);
                        m_last_d = (nst == S_EOL);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            sign_q   <= 1'b0;
            fbuf_q   <= '0;
            frac_sel <= 4'h0;
            m_valid  <= 1'b0;
            m_data   <= 8'h00;
            m_last   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            sign_q   <= sign_d;
            fbuf_q   <= fbuf_d;
            frac_sel <= frac_sel_d;
            m_valid  <= m_valid_d;
            m_data   <= m_data_d;
            m_last   <= m_last_d;
        end
    end
endmodule

// File: tb/tb_fix_ascii_streamer.sv
// Directed bench for fix_ascii_streamer: models the fraction lookup and checks byte streams.
module tb_fix_ascii_streamer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_sign = 1'b0;
    logic [7:0]  s_int = 8'h00;
    logic [3:0]  s_frac = 4'h0;
    logic [3:0]  frac_sel;
    logic [31:0] frac_ascii;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        m_last;

    int tests_run = 0;
    int tests_failed = 0;

    // results of the last run_stream call
    logic [8:0] got[$];
    int         lat, span, stall_err;
    logic [3:0] fsel_conv;
    bit         sready_bad, tmo;
    logic       mv_after, sr_after;

    fix_ascii_streamer #(.INT_W(8), .NDIG(3)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_sign(s_sign),
        .s_int(s_int), .s_frac(s_frac), .frac_sel(frac_sel), .frac_ascii(frac_ascii),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // index/16 = index*625/10000, as four ASCII digits
    function automatic logic [31:0] frac_lut(input logic [3:0] ix);
        int v;
        v = int'(ix) * 625;
        frac_lut = {8'(8'h30 + v / 1000), 8'(8'h30 + (v / 100) % 10),
                    8'(8'h30 + (v / 10) % 10), 8'(8'h30 + v % 10)};
    endfunction
    assign frac_ascii = frac_lut(frac_sel);

    // Stimulus/capture only: sends one sample and records the handshaken {m_last,m_data} bytes.
    task automatic run_stream(input logic sg, input logic [7:0] iv, input logic [3:0] fv, input bit rnd);
        int   edges, n;
        bit   done, prev_stall;
        logic [8:0] prev;
        got.delete();
        lat = -1; span = 0; stall_err = 0; sready_bad = 0; done = 0; prev_stall = 0; prev = '0;
        n = 0;
        while (!s_ready && n < 50) begin @(negedge clk); n++; end
        s_sign = sg; s_int = iv; s_frac = fv; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_int = 8'($urandom); s_frac = 4'($urandom); s_sign = 1'($urandom);
        fsel_conv = frac_sel;
        edges = 0;
        while (!done && edges < 300) begin
            if (s_ready) sready_bad = 1;
            m_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (m_valid) begin
                if (lat < 0) lat = edges;
                if (prev_stall && {m_last, m_data} !== prev) stall_err++;
                if (m_ready) begin
                    got.push_back({m_last, m_data});
                    if (m_last) done = 1;
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                    prev = {m_last, m_data};
                end
            end
            @(negedge clk);
            edges++;
        end
        span = edges - lat;
        tmo = !done;
        mv_after = m_valid;
        sr_after = s_ready;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_s_ready got %b exp 1", s_ready); end
        tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
        tests_run++; if (m_data !== 8'h00) begin tests_failed++; $display("FAIL reset_m_data got %h exp 00", m_data); end
        tests_run++; if (m_last !== 1'b0) begin tests_failed++; $display("FAIL reset_m_last got %b exp 0", m_last); end
        tests_run++; if (frac_sel !== 4'h0) begin tests_failed++; $display("FAIL reset_frac_sel got %h exp 0", frac_sel); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] exp[$] = '{8'h35, 8'h2E, 8'h32, 8'h35, 8'h30, 8'h30, 8'h0A};
        logic [8:0] e;
        run_stream(1'b0, 8'd5, 4'h4, 1'b0);
        tests_run++; if (tmo) begin tests_failed++; $display("FAIL basic_timeout got no m_last exp m_last"); end
        tests_run++; if (lat !== 9) begin tests_failed++; $display("FAIL basic_latency got %0d exp 9", lat); end
        tests_run++; if (fsel_conv !== 4'h4) begin tests_failed++; $display("FAIL basic_frac_sel got %h exp 4", fsel_conv); end
        tests_run++; if (got.size() != exp.size()) begin tests_failed++; $display("FAIL basic_len got %0d exp %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            e = {(i == exp.size() - 1), exp[i]};
            tests_run++;
            if (i >= got.size() || got[i] !== e) begin
                tests_failed++; $display("FAIL basic_byte%0d got %h exp %h", i, (i < got.size()) ? got[i] : 9'h1FF, e);
            end
        end
        tests_run++; if (mv_after !== 1'b0 || sr_after !== 1'b1) begin
            tests_failed++; $display("FAIL basic_after_eol got v=%b r=%b exp v=0 r=1", mv_after, sr_after); end
    endtask

    task automatic test_negative_max();
        logic [7:0] exp[$] = '{8'h2D, 8'h32, 8'h35, 8'h35, 8'h2E, 8'h39, 8'h33, 8'h37, 8'h35, 8'h0A};
        logic [8:0] e;
        run_stream(1'b1, 8'd255, 4'hF, 1'b0);
        tests_run++; if (tmo) begin tests_failed++; $display("FAIL neg_timeout got no m_last exp m_last"); end
        tests_run++; if (lat !== 9) begin tests_failed++; $display("FAIL neg_latency got %0d exp 9", lat); end
        tests_run++; if (fsel_conv !== 4'hF) begin tests_failed++; $display("FAIL neg_frac_sel got %h exp f", fsel_conv); end
        tests_run++; if (got.size() != exp.size()) begin tests_failed++; $display("FAIL neg_len got %0d exp %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            e = {(i == exp.size() - 1), exp[i]};
            tests_run++;
            if (i >= got.size() || got[i] !== e) begin
                tests_failed++; $display("FAIL neg_byte%0d got %h exp %h", i, (i < got.size()) ? got[i] : 9'h1FF, e);
            end
        end
    endtask

    task automatic test_zero();
        logic [7:0] exp_p[$] = '{8'h30, 8'h2E, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0A};
        logic [7:0] exp_n[$] = '{8'h2D, 8'h30, 8'h2E, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0A};
        logic [8:0] e;
        run_stream(1'b0, 8'd0, 4'h0, 1'b0);
        tests_run++; if (fsel_conv !== 4'h0) begin tests_failed++; $display("FAIL zero_frac_sel got %h exp 0", fsel_conv); end
        tests_run++; if (got.size() != exp_p.size()) begin tests_failed++; $display("FAIL zero_len got %0d exp %0d", got.size(), exp_p.size()); end
        for (int i = 0; i < exp_p.size(); i++) begin
            e = {(i == exp_p.size() - 1), exp_p[i]};
            tests_run++;
            if (i >= got.size() || got[i] !== e) begin
                tests_failed++; $display("FAIL zero_byte%0d got %h exp %h", i, (i < got.size()) ? got[i] : 9'h1FF, e);
            end
        end
        run_stream(1'b1, 8'd0, 4'h0, 1'b0);
        tests_run++; if (got.size() != exp_n.size()) begin tests_failed++; $display("FAIL negzero_len got %0d exp %0d", got.size(), exp_n.size()); end
        for (int i = 0; i < exp_n.size(); i++) begin
            e = {(i == exp_n.size() - 1), exp_n[i]};
            tests_run++;
            if (i >= got.size() || got[i] !== e) begin
                tests_failed++; $display("FAIL negzero_byte%0d got %h exp %h", i, (i < got.size()) ? got[i] : 9'h1FF, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[$] = '{8'h31, 8'h30, 8'h30, 8'h2E, 8'h30, 8'h36, 8'h32, 8'h35, 8'h0A};
        logic [8:0] e;
        run_stream(1'b0, 8'd100, 4'h1, 1'b0);
        tests_run++; if (span !== 9) begin tests_failed++; $display("FAIL b2b_cycles got %0d exp 9", span); end
        tests_run++; if (got.size() != exp.size()) begin tests_failed++; $display("FAIL b2b_len got %0d exp %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            e = {(i == exp.size() - 1), exp[i]};
            tests_run++;
            if (i >= got.size() || got[i] !== e) begin
                tests_failed++; $display("FAIL b2b_byte%0d got %h exp %h", i, (i < got.size()) ? got[i] : 9'h1FF, e);
            end
        end
    endtask

    task automatic test_stalls();
        logic [7:0] exp[$] = '{8'h2D, 8'h32, 8'h35, 8'h35, 8'h2E, 8'h39, 8'h33, 8'h37, 8'h35, 8'h0A};
        logic [8:0] e;
        run_stream(1'b1, 8'd255, 4'hF, 1'b1);
        tests_run++; if (tmo) begin tests_failed++; $display("FAIL stall_timeout got no m_last exp m_last"); end
        tests_run++; if (stall_err != 0) begin tests_failed++; $display("FAIL stall_stable got %0d changes exp 0", stall_err); end
        tests_run++; if (sready_bad) begin tests_failed++; $display("FAIL stall_s_ready got 1 during stream exp 0"); end
        tests_run++; if (mv_after !== 1'b0 || sr_after !== 1'b1) begin
            tests_failed++; $display("FAIL stall_after_eol got v=%b r=%b exp v=0 r=1", mv_after, sr_after); end
        tests_run++; if (got.size() != exp.size()) begin tests_failed++; $display("FAIL stall_len got %0d exp %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            e = {(i == exp.size() - 1), exp[i]};
            tests_run++;
            if (i >= got.size() || got[i] !== e) begin
                tests_failed++; $display("FAIL stall_byte%0d got %h exp %h", i, (i < got.size()) ? got[i] : 9'h1FF, e);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] exp[$] = '{8'h35, 8'h2E, 8'h32, 8'h35, 8'h30, 8'h30, 8'h0A};
        logic [8:0] e;
        int hs, n;
        while (!s_ready) @(negedge clk);
        s_sign = 1'b1; s_int = 8'd255; s_frac = 4'hF; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b1;
        hs = 0; n = 0;
        while (hs < 3 && n < 100) begin
            if (m_valid && m_ready) hs++;
            if (hs < 3) @(negedge clk);
            n++;
        end
        tests_run++; if (hs != 3) begin tests_failed++; $display("FAIL midrst_timeout got %0d handshakes exp 3", hs); end
        @(posedge clk);
        #2;
        tests_run++; if (m_valid !== 1'b1 || m_data !== 8'h35) begin
            tests_failed++; $display("FAIL midrst_4th_byte got v=%b d=%h exp v=1 d=35", m_valid, m_data); end
        rst = 1'b1;
        #1;
        tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_m_valid got %b exp 0", m_valid); end
        tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_s_ready got %b exp 1", s_ready); end
        tests_run++; if (frac_sel !== 4'h0) begin tests_failed++; $display("FAIL midrst_frac_sel got %h exp 0", frac_sel); end
        m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_stream(1'b0, 8'd5, 4'h4, 1'b0);
        tests_run++; if (got.size() != exp.size()) begin tests_failed++; $display("FAIL midrst_len got %0d exp %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            e = {(i == exp.size() - 1), exp[i]};
            tests_run++;
            if (i >= got.size() || got[i] !== e) begin
                tests_failed++; $display("FAIL midrst_byte%0d got %h exp %h", i, (i < got.size()) ? got[i] : 9'h1FF, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative_max();
        test_zero();
        test_back_to_back();
        test_stalls();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
